dual_button_debounce: RTL and testbench

- Input-conditioning stage directly upstream of the two-input logic system.
- Takes two raw asynchronous push-button/switch levels, synchronises them to clk and filters contact bounce.
- Drives clean levels (btn1_db, btn2_db) that connect straight to that system's in1/in2, plus one-cycle press and release pulses per channel for downstream sequential logic.

---
 rtl/dual_button_debounce.sv | 134 +++++++++++++
 tb/tb_dual_button_debounce.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/dual_button_debounce.sv
// Two-channel button conditioner: synchronises each raw level and accepts a
// new level only after it has been stable for DEBOUNCE_CYCLES clocks.
module dual_button_debounce #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_W           = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic btn1_raw,
  input  logic btn2_raw,
  output logic btn1_db,
  output logic btn2_db,
  output logic btn1_rise,
  output logic btn2_rise,
  output logic btn1_fall,
  output logic btn2_fall
);

  typedef enum logic [1:0] {
    LOW      = 2'd0,
    CHK_HIGH = 2'd1,
    HIGH     = 2'd2,
    CHK_LOW  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0] raw;
  logic [1:0] db_vec;
  logic [1:0] rise_vec;
  logic [1:0] fall_vec;

  assign raw = {btn2_raw, btn1_raw};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_chan
      logic [SYNC_STAGES-1:0] sync_reg;
      logic                   s;
      state_t                 state_reg, state_next;
      logic [CNT_W-1:0]       cnt_reg, cnt_next;
      logic                   db_reg, db_next;
      logic                   rise_reg, fall_reg;

      assign s = sync_reg[SYNC_STAGES-1];

      always_ff @(posedge clk) begin
        if (rst) begin
          sync_reg <= '0;
        end else begin
          sync_reg <= {sync_reg[SYNC_STAGES-2:0], raw[gi]};
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          state_reg <= LOW;
          cnt_reg   <= '0;
          db_reg    <= 1'b0;
          rise_reg  <= 1'b0;
          fall_reg  <= 1'b0;
        end else begin
          state_reg <= state_next;
          cnt_reg   <= cnt_next;
          db_reg    <= db_next;
          rise_reg  <= db_next & ~db_reg;
          fall_reg  <= ~db_next & db_reg;
        end
      end

      // Any disagreeing sample during a check returns to the settled state,
      // so the count always restarts from zero after a bounce.
      always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
          LOW: begin
            if (s) begin
              state_next = CHK_HIGH;
              cnt_next   = '0;
            end
          end
          CHK_HIGH: begin
            if (!s) begin
              state_next = LOW;
              cnt_next   = '0;
            end else if (cnt_reg == CNT_MAX) begin
              state_next = HIGH;
              cnt_next   = '0;
            end else begin
              cnt_next = cnt_reg + 1'b1;
            end
          end
          HIGH: begin
            if (!s) begin
              state_next = CHK_LOW;
              cnt_next   = '0;
            end
          end
          CHK_LOW: begin
            if (s) begin
              state_next = HIGH;
              cnt_next   = '0;
            end else if (cnt_reg == CNT_MAX) begin
              state_next = LOW;
              cnt_next   = '0;
            end else begin
              cnt_next = cnt_reg + 1'b1;
            end
          end
          default: begin
            state_next = LOW;
            cnt_next   = '0;
          end
        endcase
      end

      assign db_next = (state_next == HIGH) || (state_next == CHK_LOW);

      assign db_vec[gi]   = db_reg;
      assign rise_vec[gi] = rise_reg;
      assign fall_vec[gi] = fall_reg;
    end
  endgenerate

  assign btn1_db   = db_vec[0];
  assign btn2_db   = db_vec[1];
  assign btn1_rise = rise_vec[0];
  assign btn2_rise = rise_vec[1];
  assign btn1_fall = fall_vec[0];
  assign btn2_fall = fall_vec[1];

endmodule

// File: tb/tb_dual_button_debounce.sv
// Bench for dual_button_debounce: directed scenarios plus random bouncing,
// checked against a run-length model of the accept-after-stable rule.
module tb_dual_button_debounce;

  localparam int SYNC = 2;
  localparam int DEB  = 4;
  localparam int LAT  = SYNC + DEB + 1;

  logic clk = 1'b0;
  logic rst;
  logic btn1_raw, btn2_raw;
  logic btn1_db, btn2_db, btn1_rise, btn2_rise, btn1_fall, btn2_fall;

  int checks = 0;
  int errors = 0;

  // model: per-channel delay line, accepted level, run of disagreeing samples
  logic [SYNC-1:0] m_dly [2];
  logic            m_db [2];
  logic            m_rise [2];
  logic            m_fall [2];
  int              m_run [2];

  always #5 clk = ~clk;

  dual_button_debounce #(
    .SYNC_STAGES(SYNC),
    .DEBOUNCE_CYCLES(DEB),
    .CNT_W(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .btn1_raw(btn1_raw),
    .btn2_raw(btn2_raw),
    .btn1_db(btn1_db),
    .btn2_db(btn2_db),
    .btn1_rise(btn1_rise),
    .btn2_rise(btn2_rise),
    .btn1_fall(btn1_fall),
    .btn2_fall(btn2_fall)
  );

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d expected=%0d t=%0t", tag, got, exp, $time);
    end
  endtask

  // A new level is accepted once DEB+1 consecutive synchronised samples
  // disagree with the current level (the first one opens the check window).
  task automatic model_edge();
    logic [1:0] r;
    logic s;
    r = {btn2_raw, btn1_raw};
    for (int c = 0; c < 2; c++) begin
      m_rise[c] = 1'b0;
      m_fall[c] = 1'b0;
      if (rst) begin
        m_dly[c] = '0;
        m_db[c]  = 1'b0;
        m_run[c] = 0;
      end else begin
        s = m_dly[c][SYNC-1];
        m_dly[c] = {m_dly[c][SYNC-2:0], r[c]};
        if (s != m_db[c]) begin
          m_run[c]++;
          if (m_run[c] == DEB + 1) begin
            m_db[c]   = s;
            m_rise[c] = s;
            m_fall[c] = ~s;
            m_run[c]  = 0;
          end
        end else begin
          m_run[c] = 0;
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check("ch1", int'({btn1_db, btn1_rise, btn1_fall}), int'({m_db[0], m_rise[0], m_fall[0]}));
    check("ch2", int'({btn2_db, btn2_rise, btn2_fall}), int'({m_db[1], m_rise[1], m_fall[1]}));
    check("ch1_excl", int'(btn1_rise & btn1_fall), 0);
    check("ch2_excl", int'(btn2_rise & btn2_fall), 0);
  endtask

  // Counts edges until the channel's db reaches val; 0 means the bound expired.
  task automatic wait_db(input int ch, input logic val, output int n);
    n = 0;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if ((ch == 0 ? btn1_db : btn2_db) == val) begin
        n = i;
        return;
      end
    end
  endtask

  initial begin
    int n, n2, pulses, hold1, hold2;
    rst = 1'b1; btn1_raw = 1'b0; btn2_raw = 1'b0;
    for (int c = 0; c < 2; c++) begin
      m_dly[c] = '0; m_db[c] = 1'b0; m_run[c] = 0; m_rise[c] = 1'b0; m_fall[c] = 1'b0;
    end
    @(negedge clk);
    tick(); tick();
    check("reset_outs", int'({btn1_db, btn2_db, btn1_rise, btn2_rise, btn1_fall, btn2_fall}), 0);
    rst = 1'b0;
    tick(); tick();

    // clean press
    btn1_raw = 1'b1;
    wait_db(0, 1'b1, n);
    $display("press: db1 rose after %0d edges rise=%0b", n, btn1_rise);
    check("press_lat", n, LAT);
    check("press_rise", int'(btn1_rise), 1);
    check("press_ch2", int'(btn2_db), 0);
    repeat (13) tick();

    // release with glitch
    btn1_raw = 1'b0; tick(); tick();
    btn1_raw = 1'b1; tick();
    btn1_raw = 1'b0;
    wait_db(0, 1'b0, n);
    $display("release: db1 fell after %0d edges fall=%0b", n, btn1_fall);
    check("release_lat", n, LAT);
    check("release_fall", int'(btn1_fall), 1);
    tick();
    check("release_fall_1cyc", int'(btn1_fall), 0);
    repeat (10) tick();

    // bounce reject
    pulses = 0;
    btn1_raw = 1'b1; repeat (3) tick();
    btn1_raw = 1'b0; repeat (2) tick();
    btn1_raw = 1'b1; repeat (3) tick();
    btn1_raw = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      pulses += int'(btn1_db) + int'(btn1_rise) + int'(btn1_fall);
    end
    $display("bounce: activity on ch1 = %0d", pulses);
    check("bounce_quiet", pulses, 0);

    // simultaneous channels
    btn1_raw = 1'b1; btn2_raw = 1'b1;
    wait_db(0, 1'b1, n);
    check("simul_both", int'({btn2_db, btn1_rise, btn2_rise}), 7);
    $display("simul: db1 rose after %0d edges db2=%0b", n, btn2_db);
    check("simul_lat", n, LAT);
    repeat (5) tick();
    btn1_raw = 1'b0; btn2_raw = 1'b0;
    wait_db(1, 1'b0, n2);
    check("simul_fall_lat", n2, LAT);
    check("simul_fall_both", int'({btn1_db, btn1_fall, btn2_fall}), 3);
    repeat (5) tick();

    // reset in CHK_HIGH with cnt=2: edges 3,4,5 after raw rises
    btn1_raw = 1'b1;
    repeat (5) tick();
    rst = 1'b1; tick(); rst = 1'b0;
    check("rst_chk_outs", int'({btn1_db, btn1_rise, btn1_fall}), 0);
    $display("reset in check window: outputs=%0b%0b%0b", btn1_db, btn1_rise, btn1_fall);
    wait_db(0, 1'b1, n);
    check("rst_relat", n, LAT);
    check("rst_rerise", int'(btn1_rise), 1);
    repeat (3) tick();

    // reset while HIGH: no fall pulse
    rst = 1'b1; tick(); rst = 1'b0;
    check("rst_high_outs", int'({btn1_db, btn1_fall}), 0);
    $display("reset while high: db1=%0b fall1=%0b", btn1_db, btn1_fall);
    btn1_raw = 1'b0;
    repeat (10) tick();

    // random bouncing with occasional reset
    hold1 = 0; hold2 = 0;
    for (int i = 0; i < 4000; i++) begin
      if (hold1 == 0) begin
        btn1_raw = ~btn1_raw;
        hold1 = ($urandom_range(0, 2) == 0) ? $urandom_range(5, 12) : $urandom_range(1, 5);
      end
      if (hold2 == 0) begin
        btn2_raw = ~btn2_raw;
        hold2 = ($urandom_range(0, 2) == 0) ? $urandom_range(5, 12) : $urandom_range(1, 5);
      end
      hold1--; hold2--;
      rst = ($urandom_range(0, 299) == 0);
      tick();
    end
    rst = 1'b0;
    $display("random phase done: checks so far %0d", checks);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
